// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file with flags register,
// ALU carry-in select and committed-write counter.
module alu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rd_a_addr,
  input  logic [2:0]  rd_b_addr,
  output logic [15:0] rd_a_data,
  output logic [15:0] rd_b_data,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        flag_we,
  input  logic        cout_in,
  input  logic        lt_in,
  input  logic        eq_in,
  input  logic        gt_in,
  input  logic        v_in,
  input  logic        cin_sel,
  output logic        alu_cin,
  output logic [4:0]  flags,
  output logic [7:0]  wr_count
);

  logic [15:0] r_regs [8];
  logic [4:0]  r_flags;
  logic [7:0]  r_wr_count;
  logic        w_commit;

  // A write commits only when it targets R1..R7.
  assign w_commit = wr_en && (wr_addr != 3'd0);

  // Register array; R0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Status flags {C, LT, EQ, GT, V} captured from the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_flags <= '0;
    else if (flag_we)
      r_flags <= {cout_in, lt_in, eq_in, gt_in, v_in};
  end

  // Free-running count of committed writes, wraps at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wr_count <= '0;
    else if (w_commit)
      r_wr_count <= r_wr_count + 8'd1;
  end

  // Unbypassed combinational reads; R0 forced to zero.
  always_comb begin
    rd_a_data = (rd_a_addr == 3'd0) ? 16'h0000 : r_regs[rd_a_addr];
    rd_b_data = (rd_b_addr == 3'd0) ? 16'h0000 : r_regs[rd_b_addr];
  end

  // Carry-in uses only the stored C, breaking any ALU loop.
  assign alu_cin  = cin_sel & r_flags[4];
  assign flags    = r_flags;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed and random checks of alu_regfile
// against a behavioural array model.
module tb_alu_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_a_addr, rd_b_addr, wr_addr;
  logic [15:0] rd_a_data, rd_b_data, wr_data;
  logic        wr_en, flag_we, cin_sel;
  logic        cout_in, lt_in, eq_in, gt_in, v_in;
  logic        alu_cin;
  logic [4:0]  flags;
  logic [7:0]  wr_count;

  logic [15:0] m_regs [8];
  logic [4:0]  m_flags;
  int          m_cnt;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  alu_regfile dut (
    .clk(clk), .rst(rst),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we),
    .cout_in(cout_in), .lt_in(lt_in), .eq_in(eq_in),
    .gt_in(gt_in), .v_in(v_in),
    .cin_sel(cin_sel), .alu_cin(alu_cin),
    .flags(flags), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mrd(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_flags = 5'b00000;
    m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":rd_a"}, rd_a_data, mrd(rd_a_addr));
    chk({tag, ":rd_b"}, rd_b_data, mrd(rd_b_addr));
    chk({tag, ":flags"}, 16'(flags), 16'(m_flags));
    chk({tag, ":cnt"}, 16'(wr_count), 16'(m_cnt));
    chk({tag, ":cin"}, 16'(alu_cin),
        16'(cin_sel ? m_flags[4] : 1'b0));
  endtask

  // Model the edge from the inputs now applied, then advance.
  task automatic tick();
    if (!rst) begin
      if (wr_en && wr_addr != 3'd0) begin
        m_regs[wr_addr] = wr_data;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (flag_we)
        m_flags = {cout_in, lt_in, eq_in, gt_in, v_in};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {rd_a_addr, rd_b_addr, wr_addr, wr_data} = '0;
    {wr_en, flag_we, cin_sel} = '0;
    {cout_in, lt_in, eq_in, gt_in, v_in} = '0;
    model_clear();
    #12;
    check_model("reset");
    rst = 1'b0;

    // write then read on both ports
    rd_a_addr = 3'd3; rd_b_addr = 3'd3;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    #1 chk("wr3_pre", rd_a_data, 16'h0000);
    tick();
    wr_en = 1'b0;
    chk("wr3_a", rd_a_data, 16'h1234);
    chk("wr3_b", rd_b_data, 16'h1234);
    chk("wr3_cnt", 16'(wr_count), 16'd1);

    // R0 write discarded
    rd_a_addr = 3'd0;
    wr(3'd0, 16'hFFFF);
    chk("r0_rd", rd_a_data, 16'h0000);
    chk("r0_cnt", 16'(wr_count), 16'd1);

    // no bypass on same-cycle read of write target
    wr(3'd5, 16'h00AA);
    rd_a_addr = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
    #1 chk("nobyp_pre", rd_a_data, 16'h00AA);
    tick();
    wr_en = 1'b0;
    chk("nobyp_post", rd_a_data, 16'h5555);

    // carry capture and carry-in select
    flag_we = 1'b1; cout_in = 1'b1;
    tick();
    flag_we = 1'b0;
    chk("cy_flags", 16'(flags), 16'h0010);
    cin_sel = 1'b1;
    cout_in = 1'b0;
    #1 chk("cy_cin1", 16'(alu_cin), 16'd1);
    cin_sel = 1'b0;
    #1 chk("cy_cin0", 16'(alu_cin), 16'd0);

    // counter wrap from a fresh reset
    rst = 1'b1; model_clear();
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) wr(3'd1, 16'($urandom));
    chk("wrap_256", 16'(wr_count), 16'h0000);
    wr(3'd1, 16'hCAFE);
    chk("wrap_257", 16'(wr_count), 16'h0001);

    // load state, then asynchronous reset between edges
    for (int r = 2; r < 8; r++) wr(3'(r), 16'hA000 + 16'(r));
    flag_we = 1'b1;
    {cout_in, lt_in, eq_in, gt_in, v_in} = 5'b11111;
    tick();
    chk("pre_rst_flags", 16'(flags), 16'h001F);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
    cin_sel = 1'b1;
    rd_a_addr = 3'd4; rd_b_addr = 3'd7;
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("arst_a", rd_a_data, 16'h0000);
    chk("arst_b", rd_b_data, 16'h0000);
    chk("arst_flags", 16'(flags), 16'h0000);
    chk("arst_cnt", 16'(wr_count), 16'h0000);
    chk("arst_cin", 16'(alu_cin), 16'h0000);
    tick();
    check_model("arst_edge");
    chk("arst_r4", rd_a_data, 16'h0000);
    rst = 1'b0;
    tick();
    wr_en = 1'b0; flag_we = 1'b0;
    chk("post_rst_r4", rd_a_data, 16'hBEEF);
    chk("post_rst_cnt", 16'(wr_count), 16'h0001);
    chk("post_rst_flags", 16'(flags), 16'h001F);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd_a_addr = 3'($urandom);
      rd_b_addr = ($urandom_range(0, 3) == 0) ? rd_a_addr
                                               : 3'($urandom);
      wr_en = 1'($urandom);
      wr_addr = 3'($urandom);
      wr_data = 16'($urandom);
      flag_we = 1'($urandom);
      {cout_in, lt_in, eq_in, gt_in, v_in} = 5'($urandom);
      cin_sel = 1'($urandom);
      #1 check_model("rnd_pre");
      tick();
      check_model("rnd_post");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
